// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between instruction fetch (IF) and
// the MEM-stage data access. One access is in flight at a time. The arbiter
// registers the memory strobe, address, write enable and write data. It counts
// the fixed memory latency and returns a one-cycle ready pulse to the
// requester that was granted.
//
// Data requests win over fetch requests. The MEM-stage instruction is older
// than the one being fetched, so serving it first keeps program order. An
// access that has been granted is never preempted.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   if_req / if_addr        fetch request (held until if_ready), fetch address
//   if_rdata / if_ready     fetched word (valid with if_ready), completion pulse
//   dm_req / dm_we          data request (held until dm_ready), 1 = store
//   dm_addr / dm_wdata      data address and store data
//   dm_rdata / dm_ready     load data (valid with dm_ready), completion pulse
//   mem_en / mem_we         memory strobe (one cycle per access), write enable
//   mem_addr / mem_wdata    memory address and write data (held between accesses)
//   mem_rdata               memory read data, MEM_LAT cycles after mem_en
//   stall_if / stall_mem    freeze PC/IF_ID or the pipeline up to MEM_WB
//   busy                    an access is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2     // 1..15, mem_en cycle to valid read data
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DM_ACC = 2'd1,
        IF_ACC = 2'd2
    } state_t;

    // Read accesses wait the full memory latency; a store only needs the
    // strobe cycle itself, so it completes one cycle after mem_en.
    localparam logic [3:0] CNT_READ  = 4'(MEM_LAT);
    localparam logic [3:0] CNT_STORE = 4'd1;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    logic              mem_en_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              if_ready_nxt;
    logic              dm_ready_nxt;

    // -------------------------------------------------------------------------
    // State register: FSM state, latency counter and all registered outputs.
    // Reset wins over everything and abandons an in-flight access silently.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_ready  <= if_ready_nxt;
            dm_ready  <= dm_ready_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // cnt is loaded on grant and counts down once per access cycle. The ready
    // pulse is issued in the cycle after cnt==1, when cnt has reached 0. That
    // same cycle is the last access cycle, so the FSM returns to IDLE on the
    // following edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                if (dm_req) begin
                    state_nxt = DM_ACC;
                    cnt_nxt   = dm_we ? CNT_STORE : CNT_READ;
                end else if (if_req) begin
                    state_nxt = IF_ACC;
                    cnt_nxt   = CNT_READ;
                end
            end

            DM_ACC, IF_ACC: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered memory-port and ready
    // outputs. The strobe and the write enable are asserted only for the first
    // cycle of an access. Address and write data keep their last value
    // otherwise. A fetch grant leaves mem_wdata untouched.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_ready_nxt  = 1'b0;
        dm_ready_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (dm_req) begin
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                end else if (if_req) begin
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = if_addr;
                end
            end

            DM_ACC: begin
                dm_ready_nxt = (cnt == 4'd1);
            end

            IF_ACC: begin
                if_ready_nxt = (cnt == 4'd1);
            end

            default: begin
                mem_en_nxt = 1'b0;
            end
        endcase
    end

    // Read data goes straight through to both requesters. Each one qualifies
    // it with its own ready pulse.
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

    // A requester stalls from the cycle it raises req until its ready cycle.
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    assign busy = (state != IDLE);

endmodule
